// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared constants, types and helpers for the arRISCado fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // addi x0, x0, 0 : presented to decode whenever no real instruction exists
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // FETCH issues requests; DRAIN swallows stale responses after a redirect
  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  // One instruction-queue entry: the word and the PC it was fetched from
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Force a byte address onto a word boundary
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : DEPTH-entry synchronous FIFO of {pc, instr}; clear beats push/pop.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_clear,
  input  fetch_entry_t  i_data,
  output fetch_entry_t  o_head,
  output logic [CW-1:0] o_count
);

  // DEPTH is a power of two, so the pointers wrap on their own
  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Pointer and occupancy bookkeeping; clear empties the queue in one cycle
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful below r_count, so no reset
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch.sv
`default_nettype none
// ============================================================================
// Module   : fetch
// Brief    : RV32 instruction-fetch stage: PC ownership, credit-limited imem
//            requests, in-order instruction queue, stall and redirect flush.
// Revision : 1.0 - initial release
// ============================================================================
module fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] next_instruction,
  output logic [31:0] instr_pc,
  output logic        instr_valid
);

  localparam int            CW          = $clog2(DEPTH + 1);
  localparam logic [CW:0]   C_DEPTH_EXT = (CW + 1)'(DEPTH);
  localparam logic [31:0]   C_RESET_PC  = align_word(RESET_PC);

  fetch_state_e  r_state;
  logic [31:0]   r_pc;        // next address to request
  logic [31:0]   r_resp_pc;   // PC belonging to the next response to arrive
  logic [CW-1:0] r_outstanding;

  logic [CW-1:0] w_count;
  logic [CW-1:0] w_out_next;
  logic          w_credit;
  logic          w_accept;
  logic          w_resp;
  logic          w_push;
  logic          w_pop;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_data;

  // Requests in flight plus words already buffered may never exceed DEPTH,
  // which guarantees every response has a queue slot waiting for it.
  assign w_credit  = ({1'b0, r_outstanding} + {1'b0, w_count}) < C_DEPTH_EXT;
  assign imem_req  = !rst && (r_state == FETCH) && !redirect && w_credit;
  assign imem_addr = r_pc;
  assign w_accept  = imem_req && imem_ready;

  // A response with nothing outstanding is spurious and dropped entirely
  assign w_resp = imem_rvalid && (r_outstanding != '0);

  // Only live FETCH responses enter the queue; redirect kills the one in flight
  assign w_push      = w_resp && !redirect && (r_state == FETCH);
  assign instr_valid = !rst && (w_count != '0);
  assign w_pop       = instr_valid && !stall && !redirect;
  assign w_push_data = '{pc: r_resp_pc, instr: imem_rdata};

  // Outstanding count after this cycle's accept and response
  always_comb begin
    w_out_next = r_outstanding;
    if (w_accept && !w_resp)      w_out_next = r_outstanding + CW'(1);
    else if (!w_accept && w_resp) w_out_next = r_outstanding - CW'(1);
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (redirect),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Control FSM with PC, response-PC and outstanding-request tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= FETCH;
      r_pc          <= C_RESET_PC;
      r_resp_pc     <= C_RESET_PC;
      r_outstanding <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (redirect) begin
        r_pc      <= align_word(redirect_pc);
        r_resp_pc <= align_word(redirect_pc);
        r_state   <= (w_out_next != '0) ? DRAIN : FETCH;
      end else begin
        if (w_accept) r_pc      <= r_pc + 32'd4;
        if (w_push)   r_resp_pc <= r_resp_pc + 32'd4;
        if ((r_state == DRAIN) && (w_out_next == '0)) r_state <= FETCH;
      end
    end
  end

  assign next_instruction = instr_valid ? w_head.instr : NOP_INSTR;
  assign instr_pc         = instr_valid ? w_head.pc    : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch
// Brief    : Self-checking bench for fetch: directed vector table followed by
//            randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch;
  import cpu_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] next_instruction;
  logic [31:0] instr_pc;
  logic        instr_valid;

  always #5 clk = ~clk;

  fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .stall            (stall),
    .next_instruction (next_instruction),
    .instr_pc         (instr_pc),
    .instr_valid      (instr_valid)
  );

  // Memory contents: a recognisable function of the word address
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h5A00_0000;
  endfunction

  // Directed vector: inputs for one cycle and hand-derived expectations
  typedef struct {
    bit          rst;
    bit          redir;
    logic [31:0] rpc;
    bit          stall;
    bit          rdy;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
  } vec_t;

  function automatic vec_t mk(input bit r, input bit rd, input logic [31:0] rpc,
                              input bit st, input bit rdy, input bit er,
                              input logic [31:0] ea, input bit ev,
                              input logic [31:0] ep);
    vec_t v;
    v.rst = r; v.redir = rd; v.rpc = rpc; v.stall = st; v.rdy = rdy;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep;
    return v;
  endfunction

  // Memory environment: in-order pending requests with a due cycle
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t memq[$];

  // Reference model: plain counters and a queue of {pc, word}
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } qe_t;
  qe_t         m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_rpc;
  int          m_outs;
  bit          m_drain;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
  endtask

  // One clock cycle: drive inputs, compare before the edge, advance model
  task automatic run_cycle(input bit r, input bit rd, input logic [31:0] rpc,
                           input bit st, input bit rdy, input bit rnd,
                           input bit use_tbl, input vec_t v);
    bit          rv;
    bit          e_req;
    bit          e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    logic [31:0] rdt;
    bit          hs;
    logic [31:0] hs_addr;
    bit          m_rsp;

    rst = r; redirect = rd; redirect_pc = rpc; stall = st; imem_ready = rdy;
    rv = (memq.size() > 0) && (memq[0].due <= cyc) && (!rnd || $urandom_range(0, 3) != 0);
    if (rv) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_of(memq[0].addr);
    end else begin
      imem_rvalid = rnd && (memq.size() == 0) && ($urandom_range(0, 7) == 0);
      imem_rdata  = $urandom;
    end
    rdt = imem_rdata;

    @(negedge clk);
    e_req   = !r && !m_drain && !rd && ((m_outs + m_q.size()) < DEPTH);
    e_valid = !r && (m_q.size() > 0);
    e_pc    = e_valid ? m_q[0].pc  : 32'h0;
    e_ins   = e_valid ? m_q[0].ins : NOP_INSTR;
    chk("req", {31'b0, imem_req}, {31'b0, e_req});
    if (e_req) chk("addr", imem_addr, m_pc);
    chk("valid", {31'b0, instr_valid}, {31'b0, e_valid});
    chk("instr", next_instruction, e_ins);
    chk("ipc", instr_pc, e_pc);
    if (use_tbl) begin
      chk("tbl_req", {31'b0, imem_req}, {31'b0, v.e_req});
      if (v.e_req) chk("tbl_addr", imem_addr, v.e_addr);
      chk("tbl_valid", {31'b0, instr_valid}, {31'b0, v.e_valid});
      chk("tbl_ipc", instr_pc, v.e_pc);
      chk("tbl_instr", next_instruction, v.e_valid ? word_of(v.e_pc) : NOP_INSTR);
    end
    hs      = imem_req && imem_ready;
    hs_addr = imem_addr;

    @(posedge clk);
    if (r) begin
      memq.delete();
    end else begin
      if (rv) void'(memq.pop_front());
      if (hs) memq.push_back('{addr: hs_addr, due: cyc + 1 + (rnd ? int'($urandom_range(0, 2)) : 0)});
    end

    if (r) begin
      m_pc = 32'h0; m_rpc = 32'h0; m_outs = 0; m_drain = 0; m_q.delete();
    end else begin
      m_rsp = imem_rvalid && (m_outs > 0);
      if (rd) begin
        m_q.delete();
        if (m_rsp) m_outs--;
        m_pc    = {rpc[31:2], 2'b00};
        m_rpc   = m_pc;
        m_drain = (m_outs > 0);
      end else if (m_drain) begin
        if (m_rsp) m_outs--;
        if (m_outs == 0) m_drain = 0;
      end else begin
        if (e_valid && !st) void'(m_q.pop_front());
        if (m_rsp) begin
          m_q.push_back('{pc: m_rpc, ins: rdt});
          m_rpc = m_rpc + 32'd4;
          m_outs--;
        end
        if (e_req && rdy) begin
          m_pc = m_pc + 32'd4;
          m_outs++;
        end
      end
    end
    cyc++;
    #1;
  endtask

  vec_t tbl[27];
  vec_t none_v;

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    m_pc = 0; m_rpc = 0; m_outs = 0; m_drain = 0;
    none_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

    //            rst rd rpc         st rdy req addr       vld pc
    tbl[0]  = mk(1, 0, 32'h0,     0, 1, 0, 32'h0,     0, 32'h0);
    tbl[1]  = mk(0, 0, 32'h0,     0, 1, 1, 32'h0,     0, 32'h0);
    tbl[2]  = mk(0, 0, 32'h0,     0, 1, 1, 32'h4,     0, 32'h0);
    tbl[3]  = mk(0, 0, 32'h0,     0, 1, 0, 32'h0,     1, 32'h0);
    tbl[4]  = mk(0, 0, 32'h0,     0, 1, 1, 32'h8,     1, 32'h4);
    tbl[5]  = mk(0, 0, 32'h0,     0, 1, 1, 32'hC,     0, 32'h0);
    tbl[6]  = mk(0, 0, 32'h0,     0, 1, 0, 32'h0,     1, 32'h8);
    tbl[7]  = mk(0, 0, 32'h0,     0, 0, 1, 32'h10,    1, 32'hC);
    tbl[8]  = mk(0, 0, 32'h0,     0, 0, 1, 32'h10,    0, 32'h0);
    tbl[9]  = mk(0, 0, 32'h0,     0, 0, 1, 32'h10,    0, 32'h0);
    tbl[10] = mk(0, 0, 32'h0,     0, 1, 1, 32'h10,    0, 32'h0);
    tbl[11] = mk(0, 0, 32'h0,     0, 1, 1, 32'h14,    0, 32'h0);
    tbl[12] = mk(0, 0, 32'h0,     1, 1, 0, 32'h0,     1, 32'h10);
    tbl[13] = mk(0, 0, 32'h0,     1, 1, 0, 32'h0,     1, 32'h10);
    tbl[14] = mk(0, 0, 32'h0,     1, 1, 0, 32'h0,     1, 32'h10);
    tbl[15] = mk(0, 0, 32'h0,     1, 1, 0, 32'h0,     1, 32'h10);
    tbl[16] = mk(0, 0, 32'h0,     0, 1, 0, 32'h0,     1, 32'h10);
    tbl[17] = mk(0, 0, 32'h0,     0, 1, 1, 32'h18,    1, 32'h14);
    tbl[18] = mk(0, 0, 32'h0,     0, 1, 1, 32'h1C,    0, 32'h0);
    tbl[19] = mk(0, 1, 32'h103,   1, 1, 0, 32'h0,     1, 32'h18);
    tbl[20] = mk(0, 0, 32'h0,     0, 1, 1, 32'h100,   0, 32'h0);
    tbl[21] = mk(0, 0, 32'h0,     0, 1, 1, 32'h104,   0, 32'h0);
    tbl[22] = mk(0, 0, 32'h0,     0, 1, 0, 32'h0,     1, 32'h100);
    tbl[23] = mk(1, 0, 32'h0,     0, 1, 0, 32'h0,     0, 32'h0);
    tbl[24] = mk(0, 0, 32'h0,     0, 1, 1, 32'h0,     0, 32'h0);
    tbl[25] = mk(0, 0, 32'h0,     0, 1, 1, 32'h4,     0, 32'h0);
    tbl[26] = mk(0, 0, 32'h0,     0, 1, 0, 32'h0,     1, 32'h0);

    #1;
    for (int i = 0; i < 27; i++) begin
      run_cycle(tbl[i].rst, tbl[i].redir, tbl[i].rpc, tbl[i].stall, tbl[i].rdy,
                1'b0, 1'b1, tbl[i]);
    end

    // Randomized traffic: variable latency, backpressure, stalls, redirects
    // (some near the top of the address space to exercise PC wrap), resets
    for (int i = 0; i < 3000; i++) begin
      bit          r;
      bit          rd;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 199) == 0);
      rd  = ($urandom_range(0, 14) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                        : ($urandom & 32'h0000_3FFF);
      run_cycle(r, rd, rpc, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0),
                1'b1, 1'b0, none_v);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
